// File: rtl/tpu_package.sv
// Shared TPU control-path types and sizing constants.
package tpu_package;

   localparam int INSTR_SIZE = 32;
   localparam int IQ_DEPTH   = 16;
   localparam int IQ_CNT_W   = $clog2(IQ_DEPTH) + 1;

   typedef logic [INSTR_SIZE-1:0] instr_t;

endpackage

// File: rtl/instruction_fifo.sv
// Circular instruction FIFO between the host write port and TPU decode.
// Define IQ_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module instruction_fifo
   import tpu_package::*;
#(
   parameter int WIDTH     = INSTR_SIZE,
   parameter int DEPTH     = IQ_DEPTH,
   parameter int AF_THRESH = DEPTH - 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [WIDTH-1:0]       instruction_i,
   input  logic                   write_i,
   input  logic                   read_i,
   input  logic                   flush_i,
   output logic                   iq_full_o,
   output logic                   iq_empty_o,
   output logic                   iq_almost_full_o,
   output logic [$clog2(DEPTH):0] iq_count_o,
   output logic [WIDTH-1:0]       instruction_o,
`ifdef IQ_ERR_FLAGS_EN
   output logic                   iq_overflow_o,
   output logic                   iq_underflow_o,
`endif
   output logic                   instruction_valid_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_acc;
   logic             pop_acc;
   logic [CNT_W-1:0] count_next;

   // Acceptance uses the registered flags, so no input reaches an output combinationally.
   always_comb begin
      push_acc   = write_i & ~iq_full_o;
      pop_acc    = read_i & ~iq_empty_o;
      count_next = iq_count_o;
      if (push_acc && !pop_acc) begin
         count_next = iq_count_o + CNT_W'(1);
      end else if (!push_acc && pop_acc) begin
         count_next = iq_count_o - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_acc && !rst_i && !flush_i) begin
         mem[wr_ptr] <= instruction_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr              <= '0;
         rd_ptr              <= '0;
         iq_count_o          <= '0;
         iq_empty_o          <= 1'b1;
         iq_full_o           <= 1'b0;
         iq_almost_full_o    <= 1'b0;
         instruction_o       <= '0;
         instruction_valid_o <= 1'b0;
      end else if (flush_i) begin
         // instruction_o deliberately keeps the last popped word across a flush.
         wr_ptr              <= '0;
         rd_ptr              <= '0;
         iq_count_o          <= '0;
         iq_empty_o          <= 1'b1;
         iq_full_o           <= 1'b0;
         iq_almost_full_o    <= 1'b0;
         instruction_valid_o <= 1'b0;
      end else begin
         if (push_acc) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_acc) begin
            rd_ptr        <= rd_ptr + PTR_W'(1);
            instruction_o <= mem[rd_ptr];
         end
         instruction_valid_o <= pop_acc;
         iq_count_o          <= count_next;
         iq_empty_o          <= (count_next == '0);
         iq_full_o           <= (count_next == CNT_W'(DEPTH));
         iq_almost_full_o    <= (count_next >= CNT_W'(AF_THRESH));
      end
   end

`ifdef IQ_ERR_FLAGS_EN
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         iq_overflow_o  <= 1'b0;
         iq_underflow_o <= 1'b0;
      end else begin
         iq_overflow_o  <= iq_overflow_o | (write_i & iq_full_o);
         iq_underflow_o <= iq_underflow_o | (read_i & iq_empty_o);
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fifo.sv
// Directed bench for instruction_fifo at DEPTH=4, AF_THRESH=3, WIDTH=32.
module tb_instruction_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int AF    = 3;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [WIDTH-1:0] instruction_i;
   logic             write_i;
   logic             read_i;
   logic             flush_i;
   logic             iq_full_o;
   logic             iq_empty_o;
   logic             iq_almost_full_o;
   logic [2:0]       iq_count_o;
   logic [WIDTH-1:0] instruction_o;
   logic             instruction_valid_o;
`ifdef IQ_ERR_FLAGS_EN
   logic             iq_overflow_o;
   logic             iq_underflow_o;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   instruction_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .instruction_i      (instruction_i),
      .write_i            (write_i),
      .read_i             (read_i),
      .flush_i            (flush_i),
      .iq_full_o          (iq_full_o),
      .iq_empty_o         (iq_empty_o),
      .iq_almost_full_o   (iq_almost_full_o),
      .iq_count_o         (iq_count_o),
      .instruction_o      (instruction_o),
`ifdef IQ_ERR_FLAGS_EN
      .iq_overflow_o      (iq_overflow_o),
      .iq_underflow_o     (iq_underflow_o),
`endif
      .instruction_valid_o(instruction_valid_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample 1 time unit after the edge.
   task automatic cyc(input logic w, input logic r, input logic f, input logic [WIDTH-1:0] d);
      write_i       = w;
      read_i        = r;
      flush_i       = f;
      instruction_i = d;
      @(posedge clk_i);
      #1;
      write_i = 1'b0;
      read_i  = 1'b0;
      flush_i = 1'b0;
   endtask

   task automatic check_state(input string tag, input int cnt, input logic vld);
      check({tag, ".count"}, 32'(iq_count_o), 32'(cnt));
      check({tag, ".empty"}, 32'(iq_empty_o), 32'(cnt == 0));
      check({tag, ".full"}, 32'(iq_full_o), 32'(cnt == DEPTH));
      check({tag, ".afull"}, 32'(iq_almost_full_o), 32'(cnt >= AF));
      check({tag, ".valid"}, 32'(instruction_valid_o), 32'(vld));
   endtask

   task automatic push(input logic [WIDTH-1:0] d);
      cyc(1'b1, 1'b0, 1'b0, d);
   endtask

   task automatic pop_expect(input string tag, input logic [WIDTH-1:0] d, input int cnt_after);
      cyc(1'b0, 1'b1, 1'b0, '0);
      check_state(tag, cnt_after, 1'b1);
      check({tag, ".data"}, instruction_o, d);
   endtask

   initial begin
      rst_i         = 1'b1;
      write_i       = 1'b0;
      read_i        = 1'b0;
      flush_i       = 1'b0;
      instruction_i = '0;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      check_state("reset", 0, 1'b0);
      check("reset.data", instruction_o, 32'h0);
`ifdef IQ_ERR_FLAGS_EN
      check("reset.ovf", 32'(iq_overflow_o), 32'h0);
      check("reset.udf", 32'(iq_underflow_o), 32'h0);
`endif

      // Fill to full, then one dropped push.
      for (int i = 0; i < DEPTH; i++) begin
         push(32'hA0 + 32'(i));
         check_state($sformatf("fill%0d", i), i + 1, 1'b0);
      end
      push(32'hA4);
      check_state("push_full", 4, 1'b0);
`ifdef IQ_ERR_FLAGS_EN
      check("push_full.ovf", 32'(iq_overflow_o), 32'h1);
`endif

      // Drain in order, then one pop on empty.
      for (int i = 0; i < DEPTH; i++) begin
         pop_expect($sformatf("drain%0d", i), 32'hA0 + 32'(i), 3 - i);
      end
      cyc(1'b0, 1'b0, 1'b0, '0);
      check_state("idle", 0, 1'b0);
      check("idle.hold", instruction_o, 32'hA3);
      cyc(1'b0, 1'b1, 1'b0, '0);
      check_state("pop_empty", 0, 1'b0);
      check("pop_empty.hold", instruction_o, 32'hA3);
`ifdef IQ_ERR_FLAGS_EN
      check("pop_empty.udf", 32'(iq_underflow_o), 32'h1);
`endif

      // Pointer wrap.
      for (int i = 0; i < 3; i++) push(32'hC0 + 32'(i));
      for (int i = 0; i < 3; i++) pop_expect($sformatf("wrapC%0d", i), 32'hC0 + 32'(i), 2 - i);
      for (int i = 0; i < 4; i++) push(32'hB0 + 32'(i));
      check_state("wrap_full", 4, 1'b0);
      for (int i = 0; i < 4; i++) pop_expect($sformatf("wrapB%0d", i), 32'hB0 + 32'(i), 3 - i);

      // Simultaneous read/write corner cases.
      cyc(1'b1, 1'b1, 1'b0, 32'hD0);
      check_state("empty_wr", 1, 1'b0);
      push(32'hD1);
      cyc(1'b1, 1'b1, 1'b0, 32'hD2);
      check_state("mid_wr", 2, 1'b1);
      check("mid_wr.data", instruction_o, 32'hD0);
      push(32'hD3);
      push(32'hD4);
      check_state("sim_full", 4, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 32'hD5);
      check_state("full_wr", 3, 1'b1);
      check("full_wr.data", instruction_o, 32'hD1);
`ifdef IQ_ERR_FLAGS_EN
      check("full_wr.ovf", 32'(iq_overflow_o), 32'h1);
`endif
      pop_expect("after_full_wr0", 32'hD2, 2);
      pop_expect("after_full_wr1", 32'hD3, 1);
      pop_expect("after_full_wr2", 32'hD4, 0);

      // Flush with a concurrent write.
      for (int i = 0; i < 3; i++) push(32'hE0 + 32'(i));
      check_state("pre_flush", 3, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 32'hE3);
      check_state("flush", 0, 1'b0);
      check("flush.hold", instruction_o, 32'hD4);
`ifdef IQ_ERR_FLAGS_EN
      check("flush.ovf", 32'(iq_overflow_o), 32'h0);
      check("flush.udf", 32'(iq_underflow_o), 32'h0);
`endif
      push(32'hF0);
      pop_expect("post_flush", 32'hF0, 0);

      // Reset in the middle of traffic.
      push(32'h60);
      push(32'h61);
      rst_i = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 32'h62);
      rst_i = 1'b0;
      check_state("mid_reset", 0, 1'b0);
      check("mid_reset.data", instruction_o, 32'h0);
      push(32'h70);
      pop_expect("post_reset", 32'h70, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
